// File: rtl/pmodnav_spi_scheduler_if.sv
// Requester-side bus of the PmodNAV SPI scheduler: per-requester transaction
// requests in, grant/done/read-data status out.
interface pmodnav_spi_scheduler_if;
    logic [2:0]  req;
    logic [2:0]  req_rw;
    logic [20:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [7:0]  rdata;
    logic        busy;

    modport master (
        output req, req_rw, req_addr, req_wdata,
        input  grant, done, rdata, busy
    );

    modport slave (
        input  req, req_rw, req_addr, req_wdata,
        output grant, done, rdata, busy
    );
endinterface

// File: rtl/pmodnav_spi_scheduler.sv
// Round-robin scheduler that shares one mode-3 SPI master between the AG, MAG
// and ALT requesters; each transaction is one 16-bit {rw, addr, data} frame.
module pmodnav_spi_scheduler #(
    parameter int CLK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    pmodnav_spi_scheduler_if.slave       bus,
    output logic                         spi_sck_o,
    output logic                         spi_sck_t,
    output logic                         spi_io0_o,
    output logic                         spi_io0_t,
    input  logic                         spi_io1_i,
    output logic [2:0]                   spi_ss_o,
    output logic                         spi_ss_t
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [8:0] DIV      = 9'(CLK_DIV);
    localparam logic [8:0] DIV_M1   = 9'(CLK_DIV - 1);
    localparam logic [8:0] DIV2_M1  = 9'(2 * CLK_DIV - 1);

    // First requester with req set, searching upward from ptr and wrapping.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] pick;
        logic       found;
        int         c;
        pick  = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            c = (int'(ptr) + k) % 3;
            if (!found && req[c]) begin
                found = 1'b1;
                pick  = 2'(c);
            end
        end
        return pick;
    endfunction

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        sck_q, sck_d;
    logic        io0_q, io0_d;
    logic [2:0]  ss_q, ss_d;
    logic        t_q, t_d;

    logic [1:0]  pick_s;
    logic        pick_rw_s;
    logic [6:0]  pick_addr_s;
    logic [7:0]  pick_wdata_s;

    // Round-robin winner and its request fields, used only in IDLE.
    always_comb begin
        pick_s       = rr_pick(bus.req, ptr_q);
        pick_rw_s    = bus.req_rw[pick_s];
        pick_addr_s  = bus.req_addr[7 * int'(pick_s) +: 7];
        pick_wdata_s = bus.req_wdata[8 * int'(pick_s) +: 8];
    end

    // Next-state and next-output logic for the whole transaction sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ptr_d   = ptr_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        grant_d = grant_q;
        done_d  = 3'b000;
        rdata_d = rdata_q;
        sck_d   = sck_q;
        io0_d   = io0_q;
        ss_d    = ss_q;
        t_d     = t_q;
        case (state_q)
            IDLE: begin
                t_d = ~en;
                if (en && (bus.req != 3'b000)) begin
                    grant_d = 3'b001 << pick_s;
                    ptr_d   = (pick_s == 2'd2) ? 2'd0 : pick_s + 2'd1;
                    tx_d    = {pick_rw_s, pick_addr_s, pick_rw_s ? 8'h00 : pick_wdata_s};
                    cnt_d   = 9'd0;
                    state_d = SETUP;
                end else begin
                    grant_d = 3'b000;
                end
            end
            SETUP: begin
                // Select drops one cycle after the grant; SCK idles high.
                ss_d = ~grant_q;
                if (cnt_q == DIV) begin
                    state_d = SHIFT;
                    cnt_d   = 9'd0;
                    bit_d   = 4'd0;
                    sck_d   = 1'b0;
                    io0_d   = tx_q[15];
                    tx_d    = {tx_q[14:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_M1) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[14:0], spi_io1_i};
                end else begin
                    rx_d = rx_q;
                end
                if (cnt_q == DIV2_M1) begin
                    cnt_d = 9'd0;
                    if (bit_q == 4'd15) begin
                        state_d = HOLD;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sck_d = 1'b0;
                        io0_d = tx_q[15];
                        tx_d  = {tx_q[14:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_M1) begin
                    state_d = GAP;
                    cnt_d   = 9'd0;
                    ss_d    = 3'b111;
                    io0_d   = 1'b0;
                    done_d  = grant_q;
                    rdata_d = rx_q[7:0];
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            GAP: begin
                if (cnt_q == 9'd0) begin
                    grant_d = 3'b000;
                end else begin
                    grant_d = grant_q;
                end
                if (cnt_q == DIV_M1) begin
                    state_d = IDLE;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: begin
                state_d = IDLE;
                ss_d    = 3'b111;
                sck_d   = 1'b1;
                grant_d = 3'b000;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame and releases the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 9'd0;
            bit_q   <= 4'd0;
            ptr_q   <= 2'd0;
            tx_q    <= 16'h0000;
            rx_q    <= 16'h0000;
            grant_q <= 3'b000;
            done_q  <= 3'b000;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
            sck_q   <= 1'b1;
            io0_q   <= 1'b0;
            ss_q    <= 3'b111;
            t_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ptr_q   <= ptr_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            sck_q   <= sck_d;
            io0_q   <= io0_d;
            ss_q    <= ss_d;
            t_q     <= t_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign spi_sck_o = sck_q;
    assign spi_io0_o = io0_q;
    assign spi_ss_o  = ss_q;
    assign spi_sck_t = t_q;
    assign spi_io0_t = t_q;
    assign spi_ss_t  = t_q;

endmodule

// File: tb/tb_pmodnav_spi_scheduler.sv
// Directed bench for pmodnav_spi_scheduler: a CLK_DIV=4 instance for the main
// scenarios and a CLK_DIV=2 instance for a randomised frame sweep.
module tb_pmodnav_spi_scheduler;

    logic clk = 1'b0;
    logic rst;
    logic en1, en2;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmodnav_spi_scheduler_if b1();
    pmodnav_spi_scheduler_if b2();

    logic       sck1, sckt1, io01, io0t1, sst1, miso1;
    logic       sck2, sckt2, io02, io0t2, sst2, miso2;
    logic [2:0] ss1, ss2;

    pmodnav_spi_scheduler #(.CLK_DIV(4)) u_dut1 (
        .clk(clk), .rst(rst), .en(en1), .bus(b1),
        .spi_sck_o(sck1), .spi_sck_t(sckt1), .spi_io0_o(io01), .spi_io0_t(io0t1),
        .spi_io1_i(miso1), .spi_ss_o(ss1), .spi_ss_t(sst1)
    );

    pmodnav_spi_scheduler #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .bus(b2),
        .spi_sck_o(sck2), .spi_sck_t(sckt2), .spi_io0_o(io02), .spi_io0_t(io0t2),
        .spi_io1_i(miso2), .spi_ss_o(ss2), .spi_ss_t(sst2)
    );

    // Mode-3 slave models: MISO changes on SCK fall, MOSI captured on SCK rise.
    logic [7:0]  sbyte1 = 8'h00, sbyte2 = 8'h00;
    logic [15:0] mosi1 = 16'h0000, mosi2 = 16'h0000;
    logic [15:0] sf1, sf2;
    logic        all_hi1, all_hi2;
    int          bpos1 = 0, bpos2 = 0;
    assign sf1 = {8'h00, sbyte1};
    assign sf2 = {8'h00, sbyte2};
    assign all_hi1 = &ss1;
    assign all_hi2 = &ss2;
    initial begin
        miso1 = 1'b0;
        miso2 = 1'b0;
    end

    always @(negedge sck1 or posedge all_hi1) begin
        if (all_hi1) bpos1 <= 0;
        else if (!sck1) begin
            miso1 <= sf1[4'(15 - bpos1)];
            bpos1 <= bpos1 + 1;
        end
    end
    always @(negedge sck2 or posedge all_hi2) begin
        if (all_hi2) bpos2 <= 0;
        else if (!sck2) begin
            miso2 <= sf2[4'(15 - bpos2)];
            bpos2 <= bpos2 + 1;
        end
    end
    always @(posedge sck1) if (!all_hi1) mosi1 <= {mosi1[14:0], io01};
    always @(posedge sck2) if (!all_hi2) mosi2 <= {mosi2[14:0], io02};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int w, input bit want_done, input int budget, output int at);
        logic [2:0] v;
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clk);
            if (want_done) v = (w == 0) ? b1.done : b2.done;
            else           v = (w == 0) ? b1.grant : b2.grant;
            if (v != 3'b000) at = cyc;
        end
        check_eq(want_done ? "wait_done" : "wait_grant", 32'(at >= 0), 32'd1);
    endtask

    task automatic wait_idle(input int w);
        int ok;
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (((w == 0) ? b1.busy : b2.busy) == 1'b0) ok = 1;
        end
        check_eq("wait_idle", 32'(ok), 32'd1);
    endtask

    initial begin
        int tg, td, prev;
        logic [2:0] rr_exp [4];
        logic [1:0] w;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wd, sb;

        rst = 1'b1; en1 = 1'b0; en2 = 1'b0;
        b1.req = 3'b000; b1.req_rw = 3'b000; b1.req_addr = 21'h0; b1.req_wdata = 24'h0;
        b2.req = 3'b000; b2.req_rw = 3'b000; b2.req_addr = 21'h0; b2.req_wdata = 24'h0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_ss", ss1, 3'b111);
        check_eq("rst_sck", sck1, 1'b1);
        check_eq("rst_io0", io01, 1'b0);
        check_eq("rst_t", {sckt1, io0t1, sst1}, 3'b111);
        check_eq("rst_grant", b1.grant, 3'b000);
        check_eq("rst_done", b1.done, 3'b000);
        check_eq("rst_rdata", b1.rdata, 8'h00);
        check_eq("rst_busy", b1.busy, 1'b0);

        rst = 1'b0; en1 = 1'b1;
        @(negedge clk);

        // AG read of 0x0F, slave returns 0x68
        b1.req_rw = 3'b001; b1.req_addr = 21'h00000F; sbyte1 = 8'h68; b1.req = 3'b001;
        wait_for(0, 1'b0, 50, tg);
        check_eq("a_grant", b1.grant, 3'b001);
        @(negedge clk);
        check_eq("a_ss", ss1, 3'b110);
        wait_for(0, 1'b1, 300, td);
        check_eq("a_lat", 32'(td - tg), 32'd137);
        check_eq("a_done", b1.done, 3'b001);
        check_eq("a_rdata", b1.rdata, 8'h68);
        check_eq("a_mosi", mosi1, 16'h8F00);
        b1.req = 3'b000;
        wait_idle(0);

        // ALT write 0xC5 to 0x20; slave byte still captured
        b1.req_rw = 3'b000; b1.req_addr = 21'(7'h20) << 14; b1.req_wdata = 24'(8'hC5) << 16;
        sbyte1 = 8'h3A; b1.req = 3'b100;
        wait_for(0, 1'b0, 50, tg);
        check_eq("b_grant", b1.grant, 3'b100);
        b1.req_addr = 21'h1FFFFF; b1.req_wdata = 24'h000000;
        @(negedge clk);
        check_eq("b_ss", ss1, 3'b011);
        wait_for(0, 1'b1, 300, td);
        check_eq("b_lat", 32'(td - tg), 32'd137);
        check_eq("b_done", b1.done, 3'b100);
        check_eq("b_mosi", mosi1, 16'h20C5);
        check_eq("b_rdata", b1.rdata, 8'h3A);
        b1.req = 3'b000;
        wait_idle(0);

        // All three requesting: round-robin from pointer 0
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
        b1.req_rw = 3'b111; b1.req = 3'b111; prev = -1;
        for (int k = 0; k < 4; k++) begin
            wait_for(0, 1'b0, 300, tg);
            check_eq($sformatf("rr_grant%0d", k), b1.grant, rr_exp[k]);
            if (prev >= 0) check_eq($sformatf("rr_space%0d", k), 32'((tg - prev) >= 141), 32'd1);
            prev = tg;
            wait_for(0, 1'b1, 300, td);
            check_eq($sformatf("rr_done%0d", k), b1.done, rr_exp[k]);
        end
        b1.req = 3'b000;
        wait_idle(0);

        // Reset 50 cycles into a frame
        b1.req = 3'b001;
        wait_for(0, 1'b0, 50, tg);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("r_ss", ss1, 3'b111);
        check_eq("r_sck", sck1, 1'b1);
        check_eq("r_t", {sckt1, io0t1, sst1}, 3'b111);
        check_eq("r_grant", b1.grant, 3'b000);
        repeat (3) @(negedge clk);
        check_eq("r_done", b1.done, 3'b000);
        b1.req = 3'b010;
        rst = 1'b0;
        wait_for(0, 1'b0, 20, tg);
        check_eq("r_regrant", b1.grant, 3'b010);
        wait_for(0, 1'b1, 300, td);
        b1.req = 3'b000;
        wait_idle(0);

        // Enable gating and en falling mid-frame
        en1 = 1'b0; b1.req = 3'b010;
        repeat (5) @(negedge clk);
        check_eq("e_nogrant", b1.grant, 3'b000);
        check_eq("e_t_off", {sckt1, io0t1, sst1}, 3'b111);
        en1 = 1'b1;
        @(negedge clk);
        check_eq("e_grant", b1.grant, 3'b010);
        tg = cyc;
        repeat (60) @(negedge clk);
        en1 = 1'b0;
        @(negedge clk);
        check_eq("e_t_mid", {sckt1, io0t1, sst1}, 3'b000);
        wait_for(0, 1'b1, 300, td);
        check_eq("e_lat", 32'(td - tg), 32'd137);
        b1.req = 3'b000;
        wait_idle(0);
        @(negedge clk);
        check_eq("e_t_after", {sckt1, io0t1, sst1}, 3'b111);

        // CLK_DIV=2 randomised sweep
        en2 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            w = 2'($urandom_range(0, 2)); rw = 1'($urandom_range(0, 1));
            addr = 7'($urandom_range(0, 127)); wd = 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(0, 255));
            b2.req_rw = 3'(rw) << w; b2.req_addr = 21'(addr) << (7 * int'(w));
            b2.req_wdata = 24'(wd) << (8 * int'(w)); sbyte2 = sb;
            b2.req = 3'b001 << w;
            wait_for(1, 1'b0, 300, tg);
            check_eq($sformatf("s_grant%0d", k), b2.grant, 3'b001 << w);
            b2.req_rw = ~b2.req_rw; b2.req_addr = ~b2.req_addr; b2.req_wdata = ~b2.req_wdata;
            wait_for(1, 1'b1, 200, td);
            check_eq($sformatf("s_lat%0d", k), 32'(td - tg), 32'd69);
            check_eq($sformatf("s_mosi%0d", k), mosi2, {rw, addr, rw ? 8'h00 : wd});
            check_eq($sformatf("s_rdata%0d", k), b2.rdata, sb);
            b2.req = 3'b000;
            wait_idle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pmodnav_spi_scheduler.md
PMODNAV_SPI_SCHEDULER -- requirements
Module: pmodnav_spi_scheduler

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 2..255.
REQ-002 clk  in  1  single clock; all logic is on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 en  in  1  enable; when low, no new grant is issued and the SPI pins are tri-stated once idle.
REQ-005 req  in  3  per-requester transaction request; bit0=AG, bit1=MAG, bit2=ALT; held high until the matching done bit.
REQ-006 req_rw  in  3  per-requester direction; 1=read, 0=write.
REQ-007 req_addr  in  21  per-requester 7-bit register address; requester i uses bits [7i+6:7i].
REQ-008 req_wdata  in  24  per-requester write byte; requester i uses bits [8i+7:8i].
REQ-009 grant  out  3  one-hot owner of the bus; held from the grant cycle to the done cycle inclusive.
REQ-010 done  out  3  one-cycle pulse on the owner bit when its transaction completes.
REQ-011 rdata  out  8  byte captured in the data phase; valid in the done cycle and held until the next done.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 spi_sck_o / spi_sck_t  out  1/1  SPI clock and its tri-state (1=high-Z).
REQ-014 spi_io0_o / spi_io0_t  out  1/1  MOSI and its tri-state.
REQ-015 spi_io1_i  in  1  MISO.
REQ-016 spi_ss_o / spi_ss_t  out  3/1  active-low selects, index equal to requester, plus a shared tri-state.

Function
REQ-017 The FSM SHALL use the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-018 IDLE with en=1 and req!=0: grant SHALL be issued in that cycle (T) using round-robin; priority starts at the index after the last granted; after reset the order is 0,1,2.
REQ-019 At T, the owner's rw, addr and wdata SHALL be latched; later changes to the req_* inputs SHALL NOT affect the transaction in progress.
REQ-020 From T+1: spi_ss_o[owner]=0 and all other select bits 1; SETUP lasts CLK_DIV cycles with SCK held high.
REQ-021 SHIFT SHALL run in SPI mode 3 with 16 bits MSB-first and last 32*CLK_DIV cycles.
REQ-022 SHIFT bit timing: each bit starts with SCK low for CLK_DIV cycles, and io0_o is updated on the same clk edge that drives SCK low; SCK is then high for CLK_DIV cycles, and spi_io1_i is sampled on the clk edge that drives SCK high.
REQ-023 Bits 15..8 on io0_o SHALL be {rw, addr[6:0]}; bits 7..0 SHALL be wdata when writing and 0 when reading.
REQ-024 The MISO samples of bits 7..0 SHALL form rdata; capture happens for writes as well.
REQ-025 HOLD: SCK high and the owner's select still low for CLK_DIV cycles.
REQ-026 GAP: all selects high for CLK_DIV cycles; done[owner]=1 and rdata are updated in the first GAP cycle; grant clears after that cycle; IDLE is entered after GAP.
REQ-027 done SHALL occur at cycle T+34*CLK_DIV+1; the next grant SHALL be no earlier than T+35*CLK_DIV+1.
REQ-028 A requester whose req drops mid-transaction SHALL still receive done; the transaction is not aborted.
REQ-029 When several req bits are asserted in the same cycle, only the round-robin winner SHALL be granted; the others wait without loss.
REQ-030 Outside reset, io1 is never driven: no io1_o/io1_t ports exist.
REQ-031 spi_*_t SHALL be updated only in IDLE, to ~en; en falling mid-transaction completes the transaction first.
REQ-032 With en=0 in IDLE, all _t outputs SHALL be 1 and pending requests are held, not dropped.

Reset
REQ-033 On rst=1, asynchronously: state=IDLE, spi_sck_o=1, spi_io0_o=0, spi_ss_o=3'b111, all _t=1, grant=0, done=0, rdata=0, busy=0, and the round-robin pointer SHALL reset to requester 0.
REQ-034 Reset mid-SHIFT SHALL abort the transaction with no done pulse; the selects go high immediately.
REQ-035 After reset release, the first grant SHALL occur no earlier than the first clk edge with en=1.

Verification
REQ-036 CLK_DIV=4, en=1, req=001, rw=1, addr=0x0F, MISO model returns 0x68 -> io0_o bits 0x8F,0x00; ss_o=110; done=001 at T+137; rdata=0x68.
REQ-037 req=100, rw=0, addr=0x20, wdata=0xC5 -> MOSI bits 0x20,0xC5; ss_o=011; done=100 at T+137.
REQ-038 req=111 held continuously -> grant order 001,010,100,001; each grant starts no earlier than 141 cycles after the previous one.
REQ-039 rst asserted at T+50 of an active transaction -> ss_o=111, sck_o=1, all _t=1 with no done pulse; after release with req=010, grant=010.
REQ-040 en=0 with req=010 -> no grant and all _t=1; en rises -> grant at the next cycle; en falls mid-SHIFT -> done still at T+137, then _t=1.
REQ-041 CLK_DIV=2 sweep of random rw/addr/wdata against a mode-3 slave model -> all bytes match, and each done arrives at T+69.
